// File: rtl/uart_cmd_arbiter_if.sv
// uart_cmd_arbiter_if: handshake bundle between requesters, the arbiter and the UART command port.
interface uart_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CMD_PKT_LEN = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*CMD_PKT_LEN-1:0] req_cmd;
  logic uart_valid;
  logic uart_ready;
  logic [CMD_PKT_LEN-1:0] cmd;
  logic [ID_W-1:0] grant_id;
  logic busy;
  logic timeout_err;
  modport master (
    input req_valid, req_cmd, uart_ready,
    output req_ready, uart_valid, cmd, grant_id, busy, timeout_err
  );
  modport slave (
    output req_valid, req_cmd, uart_ready,
    input req_ready, uart_valid, cmd, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: round-robin sharing of one UART command port among NUM_REQ requesters; UART_ARB_STATS_EN adds per-requester grant counters.
module uart_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CMD_PKT_LEN = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic rst,
`ifdef UART_ARB_STATS_EN
  input logic stats_clr,
  output logic [NUM_REQ*16-1:0] grant_cnt,
`endif
  uart_cmd_arbiter_if.master bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;
  state_t st, nxt;
  logic [ID_W-1:0] ptr, win, idx;
  logic any, grant, tmo, terr_q;
  logic [WD_W-1:0] wd;
  logic [CMD_PKT_LEN-1:0] cmd_q;
  logic [CMD_PKT_LEN-1:0] pkt [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pkt
    assign pkt[g] = bus.req_cmd[g*CMD_PKT_LEN +: CMD_PKT_LEN];
  end
  // descending scan so the closest requester after ptr is the last to write win
  always_comb begin
    win = ptr;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign grant = st == IDLE && any;
  assign tmo = TIMEOUT_CYCLES != 0 && (st == WAIT_LO || st == WAIT_HI) && wd == WD_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    st <= rst ? IDLE : nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = any ? ISSUE : IDLE;
      ISSUE:   nxt = bus.uart_ready ? WAIT_LO : ISSUE;
      WAIT_LO: nxt = tmo ? IDLE : bus.uart_ready ? WAIT_LO : WAIT_HI;
      WAIT_HI: nxt = (tmo || bus.uart_ready) ? IDLE : WAIT_HI;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = '0;
    bus.req_ready[win] = grant;
    bus.uart_valid = st == ISSUE;
    bus.busy = st != IDLE;
    bus.cmd = cmd_q;
    bus.grant_id = ptr;
    bus.timeout_err = terr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
      cmd_q <= '0;
      wd <= '0;
      terr_q <= 1'b0;
    end else begin
      terr_q <= tmo;
      wd <= (st == WAIT_LO || st == WAIT_HI) ? wd + 1'b1 : '0;
      if (grant) begin
        ptr <= win;
        cmd_q <= pkt[win];
      end
    end
  end
`ifdef UART_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (rst || stats_clr) cnt[i] <= '0;
      else if (grant && win == ID_W'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 1'b1;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt[g];
  end
`endif
endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// tb_uart_cmd_arbiter: directed and randomized checks of uart_cmd_arbiter against a behavioural model.
module tb_uart_cmd_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int T = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_cmd_arbiter_if #(.NUM_REQ(N), .CMD_PKT_LEN(W)) bus ();
`ifdef UART_ARB_STATS_EN
  logic stats_clr = 1'b0;
  logic [N*16-1:0] grant_cnt;
`endif
  uart_cmd_arbiter #(.NUM_REQ(N), .CMD_PKT_LEN(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
`ifdef UART_ARB_STATS_EN
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt),
`endif
    .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int m_phase = 0;
  int m_ptr = N - 1;
  int m_wait = 0;
  int m_cnt [N];
  logic [W-1:0] m_cmd = '0;
  logic m_terr = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // phase: 0 idle, 1 offering packet, 2 waiting for ready low, 3 waiting for ready high
  task automatic model_step();
    int w;
    int g;
    w = winner(bus.req_valid, m_ptr);
    g = -1;
    if (rst) begin
      m_phase = 0;
      m_ptr = N - 1;
      m_cmd = '0;
      m_wait = 0;
      m_terr = 1'b0;
    end else begin
      m_terr = 1'b0;
      if (m_phase == 0) begin
        if (w >= 0) begin
          m_cmd = bus.req_cmd[w*W +: W];
          m_ptr = w;
          m_phase = 1;
          g = w;
        end
      end else if (m_phase == 1) begin
        if (bus.uart_ready) begin
          m_phase = 2;
          m_wait = 0;
        end
      end else begin
        m_wait++;
        if (m_wait == T) begin
          m_terr = 1'b1;
          m_phase = 0;
        end else if (m_phase == 2 && !bus.uart_ready) m_phase = 3;
        else if (m_phase == 3 && bus.uart_ready) m_phase = 0;
      end
    end
`ifdef UART_ARB_STATS_EN
    if (rst || stats_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    else if (g >= 0 && m_cnt[g] < 65535) m_cnt[g]++;
`endif
  endtask
  initial begin
    int w;
    logic [N*16-1:0] e;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        w = winner(bus.req_valid, m_ptr);
        chk("req_ready", 64'(bus.req_ready), (m_phase == 0 && w >= 0) ? (64'd1 << w) : 64'd0);
        chk("uart_valid", 64'(bus.uart_valid), 64'(m_phase == 1));
        chk("cmd", 64'(bus.cmd), 64'(m_cmd));
        chk("grant_id", 64'(bus.grant_id), 64'(m_ptr));
        chk("busy", 64'(bus.busy), 64'(m_phase != 0));
        chk("timeout_err", 64'(bus.timeout_err), 64'(m_terr));
`ifdef UART_ARB_STATS_EN
        for (int i = 0; i < N; i++) e[i*16 +: 16] = 16'(m_cnt[i]);
        chk("grant_cnt", 64'(grant_cnt), 64'(e));
`endif
      end
      @(posedge clk);
      model_step();
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic complete();
    bus.uart_ready = 1'b1;
    step();
    bus.uart_ready = 1'b0;
    step();
    bus.uart_ready = 1'b1;
    step();
  endtask
  initial begin
    int got [5];
    int exp_order [5];
    int pulses;
    int first;
    int p;
    logic [N-1:0] rdy50;
    exp_order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_cmd = '0;
    bus.uart_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_uart_valid", 64'(bus.uart_valid), 64'h0);
    chk("rst_cmd", 64'(bus.cmd), 64'h0);
    chk("rst_grant_id", 64'(bus.grant_id), 64'd3);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    step();
    bus.req_valid = 4'b0010;
    bus.req_cmd[1*W +: W] = 16'h8A5C;
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'b0010);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_ready_drop", 64'(bus.req_ready), 64'h0);
    chk("single_valid", 64'(bus.uart_valid), 64'h1);
    chk("single_cmd", 64'(bus.cmd), 64'h8A5C);
    chk("single_gid", 64'(bus.grant_id), 64'd1);
    step();
    bus.uart_ready = 1'b0;
    @(negedge clk);
    chk("single_valid_low", 64'(bus.uart_valid), 64'h0);
    repeat (19) step();
    step();
    bus.uart_ready = 1'b1;
    @(negedge clk);
    chk("single_busy_hold", 64'(bus.busy), 64'h1);
    step();
    @(negedge clk);
    chk("single_busy_done", 64'(bus.busy), 64'h0);
    step();
    bus.req_valid = 4'b1001;
    @(negedge clk);
    chk("rr_first", 64'(bus.req_ready), 64'b1000);
    step();
    bus.req_valid = 4'b1101;
    @(negedge clk);
    chk("rr_gid3", 64'(bus.grant_id), 64'd3);
    complete();
    @(negedge clk);
    chk("rr_second", 64'(bus.req_ready), 64'b0001);
    step();
    bus.req_valid = '0;
    complete();
    @(negedge clk);
    chk("rr_gid0", 64'(bus.grant_id), 64'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_cmd = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cont_onehot", 64'($countones(bus.req_ready)), 64'd1);
      got[i] = -1;
      for (int j = 0; j < N; j++) if (bus.req_ready[j]) got[i] = j;
      step();
      complete();
    end
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) chk("cont_order", 64'(got[i]), 64'(exp_order[i]));
    bus.req_valid = 4'b0100;
    bus.req_cmd[2*W +: W] = 16'h1234;
    bus.uart_ready = 1'b0;
    step();
    bus.req_valid = 4'b1011;
    bus.req_cmd[2*W +: W] = 16'hFFFF;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.uart_valid), 64'h1);
      chk("stall_cmd", 64'(bus.cmd), 64'h1234);
      chk("stall_no_grant", 64'(bus.req_ready), 64'h0);
      step();
    end
    bus.uart_ready = 1'b1;
    step();
    bus.uart_ready = 1'b0;
    pulses = 0;
    first = -1;
    rdy50 = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 50) rdy50 = bus.req_ready;
      step();
    end
    chk("wd_pulses", 64'(pulses), 64'd1);
    chk("wd_cycle", 64'(first), 64'd50);
    chk("wd_next_grant", 64'(rdy50), 64'b1000);
    bus.req_valid = '0;
    complete();
`ifdef UART_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) begin
      bus.req_valid = 4'b0100;
      step();
      bus.req_valid = '0;
      complete();
    end
    @(negedge clk);
    chk("stats_cnt2", 64'(grant_cnt[2*16 +: 16]), 64'd3);
    step();
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    bus.uart_ready = 1'b1;
    step();
    bus.uart_ready = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("stats_in_wait_hi", 64'(bus.busy), 64'h1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("stats_rst_cnt", 64'(grant_cnt), 64'h0);
    chk("stats_rst_gid", 64'(bus.grant_id), 64'd3);
    chk("stats_rst_busy", 64'(bus.busy), 64'h0);
    step();
    bus.req_valid = 4'b0001;
    stats_clr = 1'b1;
    step();
    bus.req_valid = '0;
    stats_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr_prio", 64'(grant_cnt), 64'h0);
    chk("stats_clr_grant", 64'(bus.uart_valid), 64'h1);
    complete();
`endif
    p = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) p = (c / 100) % 3 == 0 ? 2 : (c / 100) % 3 == 1 ? 16 : 128;
      if ($urandom_range(p - 1) == 0) bus.uart_ready = ~bus.uart_ready;
      if ($urandom_range(3) == 0) bus.req_valid = N'($urandom);
      bus.req_cmd = {$urandom, $urandom};
      rst = $urandom_range(299) == 0;
`ifdef UART_ARB_STATS_EN
      stats_clr = $urandom_range(49) == 0;
`endif
      step();
    end
    rst = 1'b0;
    step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
